// File: rtl/mmc_resp_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmc_resp_rx : CMD-line response receiver (short/long frames, CRC7, Ncr)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mmc_resp_rx #(
  parameter int SHORT_BITS     = 48,
  parameter int LONG_BITS      = 136,
  parameter int TIMEOUT_BITS   = 64,
  parameter bit SAMPLE_FALLING = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bitclk_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 long_i,
  input  logic                 crc_en_i,
  input  logic                 data_i,
  output logic [LONG_BITS-1:0] resp_o,
  output logic                 active_o,
  output logic                 complete_o,
  output logic                 timeout_o,
  output logic                 crc_err_o,
  output logic                 end_err_o
);

  localparam int IDX_W = $clog2(LONG_BITS);
  localparam int TMO_W = $clog2(TIMEOUT_BITS + 1);
  localparam logic [IDX_W-1:0] SHORT_SECOND = IDX_W'(SHORT_BITS - 2);
  localparam logic [IDX_W-1:0] LONG_SECOND  = IDX_W'(LONG_BITS - 2);
  localparam logic [IDX_W-1:0] LONG_CRC_TOP = IDX_W'(LONG_BITS - 9);
  localparam logic [IDX_W-1:0] CRC_LOW      = IDX_W'(8);
  localparam logic [TMO_W-1:0] TMO_LIMIT    = TMO_W'(TIMEOUT_BITS);
  localparam logic [TMO_W-1:0] TMO_ONE      = TMO_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RX   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 clk_q;
  logic                 long_q, long_d;
  logic                 crc_en_q, crc_en_d;
  logic [LONG_BITS-1:0] resp_q, resp_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [6:0]           crc_q, crc_d;
  logic                 timeout_q, timeout_d;
  logic                 crc_err_q, crc_err_d;
  logic                 end_err_q, end_err_d;

  logic       capture;
  logic       crc_window;
  logic [6:0] crc_upd;

  assign capture = SAMPLE_FALLING ? (~bitclk_i & clk_q) : (bitclk_i & ~clk_q);
  // Long frames exclude the 0x3F header byte from the CRC; the start bit is a
  // zero fed into a zero register, so skipping it changes nothing.
  assign crc_window = (idx_q >= CRC_LOW) && (!long_q || (idx_q <= LONG_CRC_TOP));
  assign crc_upd    = {crc_q[5:0], 1'b0} ^ ((crc_q[6] ^ data_i) ? 7'h09 : 7'h00);

  always_comb begin
    state_d   = state_q;
    long_d    = long_q;
    crc_en_d  = crc_en_q;
    resp_d    = resp_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    crc_d     = crc_q;
    timeout_d = timeout_q;
    crc_err_d = crc_err_q;
    end_err_d = end_err_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d   = S_WAIT;
            long_d    = long_i;
            crc_en_d  = crc_en_i;
            resp_d    = '0;
            crc_d     = '0;
            tmo_d     = '0;
            timeout_d = 1'b0;
            crc_err_d = 1'b0;
            end_err_d = 1'b0;
          end
        end
        S_WAIT: begin
          if (capture) begin
            if (!data_i) begin
              state_d = S_RX;
              resp_d  = {resp_q[LONG_BITS-2:0], 1'b0};
              idx_d   = long_q ? LONG_SECOND : SHORT_SECOND;
            end else if (tmo_q != TMO_LIMIT) begin
              tmo_d = tmo_q + TMO_ONE;
              if ((tmo_q + TMO_ONE) == TMO_LIMIT) begin
                state_d   = S_DONE;
                timeout_d = 1'b1;
              end
            end
          end
        end
        S_RX: begin
          if (capture) begin
            resp_d = {resp_q[LONG_BITS-2:0], data_i};
            if (crc_window) crc_d = crc_upd;
            // At the end bit the low seven received bits are the frame's CRC field.
            if (idx_q == '0) begin
              state_d   = S_DONE;
              crc_err_d = crc_en_q && (crc_q != resp_q[6:0]);
              end_err_d = ~data_i;
            end else begin
              idx_d = idx_q - IDX_ONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      clk_q     <= 1'b0;
      long_q    <= 1'b0;
      crc_en_q  <= 1'b0;
      resp_q    <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      crc_q     <= '0;
      timeout_q <= 1'b0;
      crc_err_q <= 1'b0;
      end_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_q     <= bitclk_i;
      long_q    <= long_d;
      crc_en_q  <= crc_en_d;
      resp_q    <= resp_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      crc_q     <= crc_d;
      timeout_q <= timeout_d;
      crc_err_q <= crc_err_d;
      end_err_q <= end_err_d;
    end
  end

  assign resp_o     = resp_q;
  assign active_o   = (state_q != S_IDLE);
  assign complete_o = (state_q == S_DONE);
  assign timeout_o  = timeout_q;
  assign crc_err_o  = crc_err_q;
  assign end_err_o  = end_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mmc_resp_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mmc_resp_rx : directed bench, rising- and falling-sample receivers     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mmc_resp_rx;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         bitclk_i = 1'b0;
  logic         start_i = 1'b0;
  logic         abort_i = 1'b0;
  logic         long_i = 1'b0;
  logic         crc_en_i = 1'b0;
  logic         data_i = 1'b1;

  logic [135:0] resp_r, resp_f;
  logic         active_r, active_f;
  logic         complete_r, complete_f;
  logic         timeout_r, timeout_f;
  logic         crc_err_r, crc_err_f;
  logic         end_err_r, end_err_f;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_r = 0;
  int cnt_f = 0;
  int base_r, base_f;

  always #5 clk_i = ~clk_i;

  mmc_resp_rx #(.SAMPLE_FALLING(1'b0)) u_rise (
    .clk_i(clk_i), .rst_i(rst_i), .bitclk_i(bitclk_i), .start_i(start_i),
    .abort_i(abort_i), .long_i(long_i), .crc_en_i(crc_en_i), .data_i(data_i),
    .resp_o(resp_r), .active_o(active_r), .complete_o(complete_r),
    .timeout_o(timeout_r), .crc_err_o(crc_err_r), .end_err_o(end_err_r)
  );

  mmc_resp_rx #(.SAMPLE_FALLING(1'b1)) u_fall (
    .clk_i(clk_i), .rst_i(rst_i), .bitclk_i(bitclk_i), .start_i(start_i),
    .abort_i(abort_i), .long_i(long_i), .crc_en_i(crc_en_i), .data_i(data_i),
    .resp_o(resp_f), .active_o(active_f), .complete_o(complete_f),
    .timeout_o(timeout_f), .crc_err_o(crc_err_f), .end_err_o(end_err_f)
  );

  always @(posedge clk_i) begin
    if (complete_r) cnt_r <= cnt_r + 1;
    if (complete_f) cnt_f <= cnt_f + 1;
  end

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Data is stable across both bit-clock edges, so both builds see each bit once.
  task automatic send_bit(input logic b);
    @(negedge clk_i); data_i = b;
    @(negedge clk_i); bitclk_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i); bitclk_i = 1'b0;
  endtask

  task automatic send_bits(input logic [135:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(f[i]);
  endtask

  task automatic arm(input logic lg, input logic ce);
    @(negedge clk_i); start_i = 1'b1; long_i = lg; crc_en_i = ce;
    @(negedge clk_i); start_i = 1'b0; long_i = 1'b0; crc_en_i = 1'b0;
    base_r = cnt_r;
    base_f = cnt_f;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk_i);
  endtask

  task automatic run_frame(input logic [135:0] f, input int len, input logic lg, input logic ce);
    arm(lg, ce);
    repeat (3) send_bit(1'b1);
    send_bits(f, len - 1, 0);
    settle();
  endtask

  task automatic check_done(input string tag, input logic [135:0] exp_resp,
                            input logic tmo, input logic crc, input logic endb);
    check({tag, " cnt_r"}, 136'(cnt_r - base_r), 136'd1);
    check({tag, " cnt_f"}, 136'(cnt_f - base_f), 136'd1);
    check({tag, " resp_r"}, resp_r, exp_resp);
    check({tag, " resp_f"}, resp_f, exp_resp);
    check({tag, " tmo_r"}, 136'(timeout_r), 136'(tmo));
    check({tag, " tmo_f"}, 136'(timeout_f), 136'(tmo));
    check({tag, " crc_r"}, 136'(crc_err_r), 136'(crc));
    check({tag, " crc_f"}, 136'(crc_err_f), 136'(crc));
    check({tag, " end_r"}, 136'(end_err_r), 136'(endb));
    check({tag, " end_f"}, 136'(end_err_f), 136'(endb));
    check({tag, " act_r"}, 136'(active_r), 136'd0);
    check({tag, " act_f"}, 136'(active_f), 136'd0);
  endtask

  localparam logic [135:0] F_CMD0  = 136'h400000000095;
  localparam logic [135:0] F_CMD8  = 136'h48000001AA87;
  localparam logic [135:0] F_CMD8X = 136'h48000011AA87;
  localparam logic [135:0] F_ENDB  = 136'h400000000094;
  // CID = 80 zero bits then the CMD8 payload, so its CRC7 is the CMD8 CRC 0x43.
  localparam logic [135:0] F_LONG  = 136'h3F_00000000000000000000_48000001AA_87;

  initial begin
    repeat (2) @(negedge clk_i);
    check("rst resp_r", resp_r, 136'd0);
    check("rst act_r", 136'(active_r), 136'd0);
    check("rst cmp_f", 136'(complete_f), 136'd0);
    check("rst flags_r", 136'({timeout_r, crc_err_r, end_err_r}), 136'd0);
    @(negedge clk_i); rst_i = 1'b0;
    settle();

    run_frame(F_CMD0, 48, 1'b0, 1'b1);
    check_done("t1", F_CMD0, 1'b0, 1'b0, 1'b0);

    run_frame(F_CMD8, 48, 1'b0, 1'b1);
    check_done("t2", F_CMD8, 1'b0, 1'b0, 1'b0);

    run_frame(F_CMD8X, 48, 1'b0, 1'b1);
    check_done("t2x", F_CMD8X, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clk_i);
    check("t2x hold crc_r", 136'(crc_err_r), 136'd1);
    check("t2x hold resp_f", resp_f, F_CMD8X);

    run_frame(F_ENDB, 48, 1'b0, 1'b1);
    check_done("t3e", F_ENDB, 1'b0, 1'b0, 1'b1);

    run_frame(F_CMD8X, 48, 1'b0, 1'b0);
    check_done("t3n", F_CMD8X, 1'b0, 1'b0, 1'b0);

    arm(1'b0, 1'b1);
    repeat (63) send_bit(1'b1);
    settle();
    check("t4 63 cnt_r", 136'(cnt_r - base_r), 136'd0);
    check("t4 63 cnt_f", 136'(cnt_f - base_f), 136'd0);
    check("t4 63 act_r", 136'(active_r), 136'd1);
    check("t4 63 act_f", 136'(active_f), 136'd1);
    send_bit(1'b1);
    settle();
    check_done("t4", 136'd0, 1'b1, 1'b0, 1'b0);

    run_frame(F_LONG, 136, 1'b1, 1'b1);
    check_done("t5", F_LONG, 1'b0, 1'b0, 1'b0);

    arm(1'b0, 1'b1);
    send_bit(1'b1);
    send_bits(F_CMD0, 47, 28);
    @(negedge clk_i); abort_i = 1'b1;
    @(negedge clk_i); abort_i = 1'b0;
    check("t6 abort act_r", 136'(active_r), 136'd0);
    check("t6 abort act_f", 136'(active_f), 136'd0);
    settle();
    check("t6 abort cnt_r", 136'(cnt_r - base_r), 136'd0);
    check("t6 abort cnt_f", 136'(cnt_f - base_f), 136'd0);
    check("t6 abort resp_r", resp_r, 136'h40000);
    check("t6 abort resp_f", resp_f, 136'h40000);

    @(negedge clk_i); abort_i = 1'b1; start_i = 1'b1;
    @(negedge clk_i); abort_i = 1'b0; start_i = 1'b0;
    check("t6 abort+start act_r", 136'(active_r), 136'd0);
    check("t6 abort+start act_f", 136'(active_f), 136'd0);

    run_frame(F_CMD0, 48, 1'b0, 1'b1);
    check_done("t6 rerun", F_CMD0, 1'b0, 1'b0, 1'b0);

    arm(1'b0, 1'b1);
    send_bit(1'b1);
    send_bits(F_CMD8, 47, 38);
    #2 rst_i = 1'b1;
    #1;
    check("t6 rst resp_r", resp_r, 136'd0);
    check("t6 rst resp_f", resp_f, 136'd0);
    check("t6 rst act_r", 136'(active_r), 136'd0);
    check("t6 rst act_f", 136'(active_f), 136'd0);
    check("t6 rst flags_f", 136'({complete_f, timeout_f, crc_err_f, end_err_f}), 136'd0);
    @(negedge clk_i); rst_i = 1'b0;
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
